// File: rtl/risc_sequencer.sv
// Instruction sequencer for the RISC-Y core: FETCH/DECODE/EXECUTE/UPDATE control
// with memory wait states, run/halt/single-step and a sticky memory-timeout fault.
module risc_sequencer #(
   parameter int unsigned OPW      = 4,
   parameter int unsigned WAIT_MAX = 7,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             RUN,
   input  logic             STEP,
   input  logic [OPW-1:0]   OPCODE,
   input  logic             ZERO,
   input  logic             MEM_RDY,
   output logic [1:0]       PHASE,
   output logic             MEM_RD,
   output logic             MEM_WR,
   output logic             IR_LD,
   output logic             PC_INC,
   output logic             PC_LD,
   output logic             ACC_LD,
   output logic             INSTR_DONE,
   output logic             HALTED,
   output logic             FAULT,
   output logic [CNT_W-1:0] INSTR_CNT
);

   localparam int unsigned WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

   localparam logic [OPW-1:0] OP_HLT = OPW'(0);
   localparam logic [OPW-1:0] OP_LDA = OPW'(1);
   localparam logic [OPW-1:0] OP_STO = OPW'(2);
   localparam logic [OPW-1:0] OP_ADD = OPW'(3);
   localparam logic [OPW-1:0] OP_JMP = OPW'(4);
   localparam logic [OPW-1:0] OP_SKZ = OPW'(5);

   typedef enum logic [2:0] {
      S_HALT    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXECUTE = 3'd3,
      S_UPDATE  = 3'd4
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             step_q;
   logic [WCW-1:0]   wcnt_q;
   logic             mem_req;
   logic             timeout;

   assign mem_req = MEM_RD | MEM_WR;
   // A request still unanswered after WAIT_MAX counted wait cycles aborts the instruction.
   assign timeout = mem_req && !MEM_RDY && (wcnt_q == WCW'(WAIT_MAX));

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_HALT;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HALT: begin
            if (!FAULT && (RUN || STEP)) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (MEM_RDY)      state_d = S_DECODE;
            else if (timeout) state_d = S_HALT;
         end
         S_DECODE: begin
            state_d = (OPCODE == OP_HLT) ? S_HALT : S_EXECUTE;
         end
         S_EXECUTE: begin
            if (!mem_req || MEM_RDY) state_d = S_UPDATE;
            else if (timeout)        state_d = S_HALT;
         end
         S_UPDATE: begin
            state_d = (RUN && !step_q) ? S_FETCH : S_HALT;
         end
         default: state_d = S_HALT;
      endcase
   end

   // Output decode from the registered state
   always_comb begin
      PHASE      = 2'd0;
      MEM_RD     = 1'b0;
      MEM_WR     = 1'b0;
      IR_LD      = 1'b0;
      PC_INC     = 1'b0;
      PC_LD      = 1'b0;
      ACC_LD     = 1'b0;
      INSTR_DONE = 1'b0;
      HALTED     = 1'b0;
      case (state_q)
         S_HALT: HALTED = 1'b1;
         S_FETCH: begin
            MEM_RD = 1'b1;
            IR_LD  = MEM_RDY;
         end
         S_DECODE: begin
            PHASE  = 2'd1;
            PC_INC = 1'b1;
         end
         S_EXECUTE: begin
            PHASE = 2'd2;
            case (OPCODE)
               OP_LDA, OP_ADD: begin
                  MEM_RD = 1'b1;
                  ACC_LD = MEM_RDY;
               end
               OP_STO:  MEM_WR = 1'b1;
               OP_JMP:  PC_LD  = 1'b1;
               OP_SKZ:  PC_INC = ZERO;
               default: ;
            endcase
         end
         S_UPDATE: begin
            PHASE      = 2'd3;
            INSTR_DONE = 1'b1;
         end
         default: HALTED = 1'b1;
      endcase
   end

   // Single-step arm, wait counter, fault flag and retire counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         step_q    <= 1'b0;
         wcnt_q    <= '0;
         FAULT     <= 1'b0;
         INSTR_CNT <= '0;
      end else begin
         if (state_q == S_HALT && !FAULT && STEP)
            step_q <= 1'b1;
         else if (state_q == S_UPDATE || (state_q == S_DECODE && OPCODE == OP_HLT) || timeout)
            step_q <= 1'b0;

         if (state_d != state_q || MEM_RDY || !mem_req) wcnt_q <= '0;
         else                                           wcnt_q <= wcnt_q + WCW'(1);

         if (timeout) FAULT <= 1'b1;

         if (state_q == S_UPDATE) INSTR_CNT <= INSTR_CNT + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_risc_sequencer.sv
// Directed table-driven bench for risc_sequencer: per-cycle input/expected-output
// records plus a hand-written timeout latency sequence.
module tb_risc_sequencer;

   logic        CLK = 1'b0;
   logic        RST, RUN, STEP, ZERO, MEM_RDY;
   logic [3:0]  OPCODE;
   logic [1:0]  PHASE;
   logic        MEM_RD, MEM_WR, IR_LD, PC_INC, PC_LD, ACC_LD, INSTR_DONE, HALTED, FAULT;
   logic [15:0] INSTR_CNT;

   always #5 CLK = ~CLK;

   risc_sequencer #(.OPW(4), .WAIT_MAX(7), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .OPCODE(OPCODE), .ZERO(ZERO),
      .MEM_RDY(MEM_RDY), .PHASE(PHASE), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR),
      .IR_LD(IR_LD), .PC_INC(PC_INC), .PC_LD(PC_LD), .ACC_LD(ACC_LD),
      .INSTR_DONE(INSTR_DONE), .HALTED(HALTED), .FAULT(FAULT), .INSTR_CNT(INSTR_CNT)
   );

   // Strobe vector order: {MEM_RD, MEM_WR, IR_LD, PC_INC, PC_LD, ACC_LD, INSTR_DONE}
   localparam logic [6:0] NONE  = 7'b0000000;
   localparam logic [6:0] FI    = 7'b1010000;
   localparam logic [6:0] RD    = 7'b1000000;
   localparam logic [6:0] RDACC = 7'b1000010;
   localparam logic [6:0] WR    = 7'b0100000;
   localparam logic [6:0] INC   = 7'b0001000;
   localparam logic [6:0] PCLD  = 7'b0000100;
   localparam logic [6:0] DONE  = 7'b0000001;

   typedef struct {
      logic        rst, run, step;
      logic [3:0]  op;
      logic        zero, rdy;
      logic [1:0]  ph;
      logic        halted;
      logic [6:0]  st;
      logic        fault;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic rst, run, step, input logic [3:0] op, input logic zero, rdy,
                      input logic [1:0] ph, input logic h, input logic [6:0] st,
                      input logic f, input logic [15:0] cnt);
      vec_t v;
      v.rst = rst; v.run = run; v.step = step; v.op = op; v.zero = zero; v.rdy = rdy;
      v.ph = ph; v.halted = h; v.st = st; v.fault = f; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
      end
   endtask

   initial begin
      logic [6:0] st;
      int cyc, rd_cycles;
      RST = 1'b1; RUN = 1'b0; STEP = 1'b0; OPCODE = 4'd7; ZERO = 1'b0; MEM_RDY = 1'b0;
      repeat (2) @(posedge CLK);

      // NOP, NOP, HLT under RUN with MEM_RDY high
      add(1,0,0,7,0,0, 0,1,NONE,0,0);
      add(0,1,0,7,0,1, 0,1,NONE,0,0);
      for (int n = 0; n < 2; n++) begin
         add(0,1,0,7,0,1, 0,0,FI,  0,16'(n));
         add(0,1,0,7,0,1, 1,0,INC, 0,16'(n));
         add(0,1,0,7,0,1, 2,0,NONE,0,16'(n));
         add(0,1,0,7,0,1, 3,0,DONE,0,16'(n));
      end
      add(0,1,0,0,0,1, 0,0,FI,  0,2);
      add(0,1,0,0,0,1, 1,0,INC, 0,2);
      add(0,0,0,0,0,1, 0,1,NONE,0,2);
      // LDA with 3 fetch waits and 2 execute waits; RUN drops mid-instruction
      add(0,1,0,1,0,0, 0,1,NONE,0,2);
      for (int n = 0; n < 3; n++) add(0,1,0,1,0,0, 0,0,RD,0,2);
      add(0,1,0,1,0,1, 0,0,FI,   0,2);
      add(0,0,0,1,0,1, 1,0,INC,  0,2);
      for (int n = 0; n < 2; n++) add(0,0,0,1,0,0, 2,0,RD,0,2);
      add(0,0,0,1,0,1, 2,0,RDACC,0,2);
      add(0,0,0,1,0,1, 3,0,DONE, 0,2);
      // Single-step ADD
      add(0,0,1,3,0,1, 0,1,NONE, 0,3);
      add(0,0,0,3,0,1, 0,0,FI,   0,3);
      add(0,0,0,3,0,1, 1,0,INC,  0,3);
      add(0,0,0,3,0,1, 2,0,RDACC,0,3);
      add(0,0,0,3,0,1, 3,0,DONE, 0,3);
      // Single-step SKZ with ZERO=1
      add(0,0,1,5,1,1, 0,1,NONE,0,4);
      add(0,0,0,5,1,1, 0,0,FI,  0,4);
      add(0,0,0,5,1,1, 1,0,INC, 0,4);
      add(0,0,0,5,1,1, 2,0,INC, 0,4);
      add(0,0,0,5,1,1, 3,0,DONE,0,4);
      // Running SKZ with ZERO=0, STEP while running must not arm single-step
      add(0,1,0,5,0,1, 0,1,NONE,0,5);
      add(0,1,1,5,0,1, 0,0,FI,  0,5);
      add(0,1,0,5,0,1, 1,0,INC, 0,5);
      add(0,1,0,5,0,1, 2,0,NONE,0,5);
      add(0,1,0,5,0,1, 3,0,DONE,0,5);
      // JMP then STO back-to-back
      add(0,1,0,4,0,1, 0,0,FI,  0,6);
      add(0,1,0,4,0,1, 1,0,INC, 0,6);
      add(0,1,0,4,0,1, 2,0,PCLD,0,6);
      add(0,1,0,4,0,1, 3,0,DONE,0,6);
      add(0,1,0,2,0,1, 0,0,FI,  0,7);
      add(0,1,0,2,0,1, 1,0,INC, 0,7);
      add(0,1,0,2,0,1, 2,0,WR,  0,7);
      add(0,0,0,2,0,1, 3,0,DONE,0,7);
      // STO aborted by reset while MEM_WR is high
      add(0,1,0,2,0,0, 0,1,NONE,0,8);
      add(0,1,0,2,0,1, 0,0,FI,  0,8);
      add(0,0,0,2,0,1, 1,0,INC, 0,8);
      add(0,0,0,2,0,0, 2,0,WR,  0,8);
      add(1,0,0,2,0,0, 2,0,WR,  0,8);
      add(0,0,0,2,0,0, 0,1,NONE,0,0);
      // MEM_RDY on the cycle the wait counter reaches WAIT_MAX is a success
      add(0,1,0,7,0,0, 0,1,NONE,0,0);
      for (int n = 0; n < 7; n++) add(0,1,0,7,0,0, 0,0,RD,0,0);
      add(0,0,0,7,0,1, 0,0,FI,  0,0);
      add(0,0,0,7,0,1, 1,0,INC, 0,0);
      add(0,0,0,7,0,1, 2,0,NONE,0,0);
      add(0,0,0,7,0,1, 3,0,DONE,0,0);
      // Timeout in FETCH: fault is sticky, RUN/STEP ignored until reset
      add(0,1,0,7,0,0, 0,1,NONE,0,1);
      for (int n = 0; n < 8; n++) add(0,1,0,7,0,0, 0,0,RD,0,1);
      add(0,1,1,7,0,1, 0,1,NONE,1,1);
      add(0,1,1,7,0,1, 0,1,NONE,1,1);
      add(1,0,0,7,0,1, 0,1,NONE,1,1);
      add(0,0,0,7,0,1, 0,1,NONE,0,0);

      foreach (tbl[i]) begin
         @(negedge CLK);
         RST = tbl[i].rst; RUN = tbl[i].run; STEP = tbl[i].step;
         OPCODE = tbl[i].op; ZERO = tbl[i].zero; MEM_RDY = tbl[i].rdy;
         #1;
         st = {MEM_RD, MEM_WR, IR_LD, PC_INC, PC_LD, ACC_LD, INSTR_DONE};
         chk("phase",   i, 16'(PHASE),     16'(tbl[i].ph));
         chk("halted",  i, 16'(HALTED),    16'(tbl[i].halted));
         chk("strobes", i, 16'(st),        16'(tbl[i].st));
         chk("fault",   i, 16'(FAULT),     16'(tbl[i].fault));
         chk("cnt",     i, INSTR_CNT,      tbl[i].cnt);
      end

      // Timeout latency measured by waiting on FAULT with a bounded cycle budget
      cyc = -1; rd_cycles = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge CLK);
         RST = 1'b0; RUN = 1'b1; STEP = 1'b0; MEM_RDY = 1'b0;
         #1;
         if (FAULT) begin
            cyc = n;
            break;
         end
         if (MEM_RD) rd_cycles++;
      end
      chk("fault_latency", 900, 16'(cyc),       16'd9);
      chk("fault_rd_cyc",  901, 16'(rd_cycles), 16'd8);
      chk("fault_halted",  902, 16'(HALTED),    16'd1);

      @(negedge CLK);
      RST = 1'b1; RUN = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("post_rst_fault", 903, 16'(FAULT), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
